kpn_split_stage: RTL and testbench
==================================

# kpn_split_stage

Paced fork (split) actor of the KPN demo: accepts one token from its input channel per rising edge of the divided slow clock and copies it to two output channels with independent valid/ready handshakes. Sits directly downstream of the clock divider, whose slow output drives `tick_src`, and upstream of the two consumer actors and the LCD display path. At 1–10 Hz pacing, token flow is visible on the LCD through `last_token` and `token_count`.

## Interface
- `W`, 8: token width in bits.
- `CNT_W`, 16: width of the delivered-token counter.

- `clk_in`  input  1  system clock (50 MHz); the only clock. `tick_src` is a data input, never a clock.
- `reset`  input  1  synchronous, active-high reset.
- `tick_src`  input  1  divided clock from the clock divider. Registered in the `clk_in` domain; only its 0→1 transition is used.
- `in_data`  input  W  input token.
- `in_valid`  input  1  input token present.
- `in_ready`  output  1  stage accepts a token this cycle.
- `out_a_data` / `out_b_data`  output  W  copy of the captured token.
- `out_a_valid` / `out_b_valid`  output  1  output token present.
- `out_a_ready` / `out_b_ready`  input  1  consumer accepts.
- `last_token`  output  W  most recently captured token, for the LCD.
- `token_count`  output  CNT_W  tokens fully delivered to both outputs.
- `tick_lost`  output  1  sticky flag: a tick edge was dropped.

## Operation
- Edge detect: `tick_q` <= `tick_src` every cycle. `edge` = `tick_src & ~tick_q`. `tick_q` resets to 1, so a high `tick_src` at reset release produces no edge.
- `pending` flag (one deep):
  - Set by `edge`.
  - Cleared when the FSM leaves WAIT.
  - An `edge` while `pending` is already set is dropped and sets `tick_lost`. Only `reset` clears `tick_lost`.
- FSM states:
  - **WAIT**: go to ACCEPT when `pending` or `edge`.
  - **ACCEPT**: `in_ready` = 1. On `in_valid & in_ready`:
    - capture `in_data` into the token register and into `last_token`;
    - set `a_busy` = `b_busy` = 1;
    - go to DELIVER.
  - **DELIVER**:
    - `out_x_valid` = `x_busy`.
    - `x_busy` clears on `out_x_valid & out_x_ready`, independently per port.
    - When both are clear (including both clearing in the same cycle), increment `token_count` and go to WAIT.
- `in_ready` is asserted only in ACCEPT. `out_*_data` is held stable while the corresponding valid is high.
- `token_count` wraps from 2^CNT_W−1 to 0.
- An edge arriving in ACCEPT or DELIVER is held in `pending`, so the next cycle spends at most one cycle in WAIT.
- Outputs are functions of registered state only. There are no combinational paths from ready to valid or from valid to ready.

## Timing
- Reset values:
  - state = WAIT; `in_ready` = 0;
  - `out_a_valid` = `out_b_valid` = 0; `out_*_data` = 0;
  - `last_token` = 0; `token_count` = 0; `tick_lost` = 0; `pending` = 0.
- `tick_src` first sampled high at cycle n (with `tick_q` = 0): state = ACCEPT at n+1, so `in_ready` is high at n+1.
- Input handshake at cycle k: `out_a_valid` = `out_b_valid` = 1 and `last_token` updated at k+1.
- Output handshakes: the last completing one at cycle m gives `token_count` +1 and state WAIT at m+1. Minimum token period is 3 cycles.
- Reset asserted mid-operation: on the next edge all state returns to reset values, and the held token is discarded (not delivered, not counted).
- `in_valid` low in ACCEPT: the stage waits indefinitely. Edges during the wait go to `pending`/`tick_lost`.

## Configuration
- `SPLIT_PACE_EN` defined: pacing as above.
- `SPLIT_PACE_EN` undefined:
  - the WAIT → ACCEPT transition is unconditional, so the stage runs at full handshake rate;
  - `tick_src` is ignored;
  - `pending` and `tick_lost` are tied to 0.

## Test plan
- **Reset with `tick_src` = 1:** hold `reset` 2 cycles with `tick_src` = 1, release, keep `tick_src` = 1 for 10 cycles → `in_ready` stays 0, all outputs 0.
- **Single token:** `tick_src` 0→1 at cycle 5, `in_data` = 0xA5 with `in_valid` = 1, both readies 1.
  - `in_ready` high at 6.
  - Both valids high at 7 with data 0xA5, and `last_token` = 0xA5.
  - `token_count` = 1 at 8.
- **Skewed consumers:** `out_a_ready` = 1, `out_b_ready` held 0 for 20 cycles then 1 → `out_a_valid` drops after 1 cycle; `out_b_valid` holds 0xA5 stable for 20 cycles; `token_count` increments one cycle after the B handshake.
- **Tick overrun:** with consumers stalled, apply 3 tick edges during DELIVER → `pending` = 1 after the first edge, `tick_lost` = 1 after the second. After release, exactly one immediate extra ACCEPT follows.
- **Counter wrap:** with CNT_W = 4, deliver 17 tokens → `token_count` reads 15, then 0, then 1.
- **Reset mid-DELIVER and unpaced mode:**
  - Assert `reset` while both valids are high → next cycle both valids = 0 and `token_count` unchanged from 0 after reset.
  - Rebuild without `SPLIT_PACE_EN`: 4 back-to-back tokens are delivered with a 3-cycle period.

Source files
------------

// File: rtl/kpn_split_stage.sv
// kpn_split_stage: fork actor of the KPN demo. Accepts one token per rising
// edge of the divided tick and copies it to two independently handshaked
// output channels. Optional macro SPLIT_PACE_EN enables tick pacing; when it
// is undefined the stage runs at full handshake rate and ignores tick_src.
module kpn_split_stage #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             tick_src,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_a_data,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [W-1:0]     out_b_data,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [W-1:0]     last_token,
   output logic [CNT_W-1:0] token_count,
   output logic             tick_lost
);

   localparam logic [1:0] S_WAIT    = 2'd0;
   localparam logic [1:0] S_ACCEPT  = 2'd1;
   localparam logic [1:0] S_DELIVER = 2'd2;

   logic [1:0]       r_state;
   logic [W-1:0]     r_token;
   logic [W-1:0]     r_last;
   logic             r_a_busy;
   logic             r_b_busy;
   logic [CNT_W-1:0] r_count;
   logic             w_go;
   logic             w_a_left;
   logic             w_b_left;

`ifdef SPLIT_PACE_EN
   logic r_tick_q;
   logic r_pending;
   logic r_tick_lost;
   logic w_edge;

   // Register the divided clock; resetting high hides a tick already high at release.
   always_ff @(posedge clk_in) begin
      if (reset) r_tick_q <= 1'b1;
      else       r_tick_q <= tick_src;
   end

   assign w_edge = tick_src & ~r_tick_q;
   assign w_go   = r_pending | w_edge;

   // One-deep tick buffer; an edge arriving while one is already held is dropped.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_pending   <= 1'b0;
         r_tick_lost <= 1'b0;
      end else begin
         if (w_edge && r_pending) r_tick_lost <= 1'b1;
         if ((r_state == S_WAIT) && w_go) r_pending <= 1'b0;
         else if (w_edge)                 r_pending <= 1'b1;
      end
   end

   assign tick_lost = r_tick_lost;
`else
   logic w_unused_tick;

   assign w_unused_tick = tick_src;
   assign w_go          = 1'b1;
   assign tick_lost     = 1'b0;
`endif

   assign w_a_left = r_a_busy & ~out_a_ready;
   assign w_b_left = r_b_busy & ~out_b_ready;

   // Sequencer: wait for a tick, take one token, hold it until both ports took it.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state  <= S_WAIT;
         r_token  <= '0;
         r_last   <= '0;
         r_a_busy <= 1'b0;
         r_b_busy <= 1'b0;
         r_count  <= '0;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (w_go) r_state <= S_ACCEPT;
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  r_token  <= in_data;
                  r_last   <= in_data;
                  r_a_busy <= 1'b1;
                  r_b_busy <= 1'b1;
                  r_state  <= S_DELIVER;
               end
            end
            S_DELIVER: begin
               r_a_busy <= w_a_left;
               r_b_busy <= w_b_left;
               if (!w_a_left && !w_b_left) begin
                  r_count <= r_count + CNT_W'(1);
                  r_state <= S_WAIT;
               end
            end
            default: r_state <= S_WAIT;
         endcase
      end
   end

   assign in_ready    = (r_state == S_ACCEPT);
   assign out_a_valid = r_a_busy;
   assign out_b_valid = r_b_busy;
   assign out_a_data  = r_token;
   assign out_b_data  = r_token;
   assign last_token  = r_last;
   assign token_count = r_count;

endmodule

// File: tb/tb_kpn_split_stage.sv
// tb_kpn_split_stage: directed bench for kpn_split_stage with a flag-based
// token model checked every cycle, plus literal expectations per scenario.
// Adapts its expectations to SPLIT_PACE_EN.
`timescale 1ns/1ps
module tb_kpn_split_stage;

`ifdef SPLIT_PACE_EN
   localparam bit PACED = 1'b1;
`else
   localparam bit PACED = 1'b0;
`endif
   localparam int W     = 8;
   localparam int CNT_W = 4;

   logic             clk_in      = 1'b0;
   logic             reset       = 1'b1;
   logic             tick_src    = 1'b1;
   logic [W-1:0]     in_data     = '0;
   logic             in_valid    = 1'b0;
   logic             out_a_ready = 1'b1;
   logic             out_b_ready = 1'b1;
   logic             in_ready;
   logic [W-1:0]     out_a_data;
   logic [W-1:0]     out_b_data;
   logic             out_a_valid;
   logic             out_b_valid;
   logic [W-1:0]     last_token;
   logic [CNT_W-1:0] token_count;
   logic             tick_lost;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk_in = ~clk_in;

   kpn_split_stage #(.W(W), .CNT_W(CNT_W)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .tick_src    (tick_src),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_a_data  (out_a_data),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b_data  (out_b_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .last_token  (last_token),
      .token_count (token_count),
      .tick_lost   (tick_lost)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a token is either being offered for, owed to consumers, or absent.
   bit          m_tick_prev = 1'b1;
   bit          m_accepting = 1'b0;
   bit          m_owe_a     = 1'b0;
   bit          m_owe_b     = 1'b0;
   bit          m_pend      = 1'b0;
   bit          m_lost      = 1'b0;
   logic [W-1:0] m_tok      = '0;
   logic [W-1:0] m_last     = '0;
   int unsigned m_count     = 0;
   bit          m_edge;
   bit          m_idle;
   bit          m_leave;

   always @(posedge clk_in) begin
      m_edge  = PACED && tick_src && !m_tick_prev;
      m_idle  = !m_accepting && !m_owe_a && !m_owe_b;
      m_leave = m_idle && (!PACED || m_pend || m_edge);
      if (reset) begin
         m_tick_prev = 1'b1;
         m_accepting = 1'b0;
         m_owe_a     = 1'b0;
         m_owe_b     = 1'b0;
         m_pend      = 1'b0;
         m_lost      = 1'b0;
         m_tok       = '0;
         m_last      = '0;
         m_count     = 0;
      end else begin
         m_tick_prev = tick_src;
         if (m_edge && m_pend) m_lost = 1'b1;
         if (m_accepting) begin
            if (in_valid) begin
               m_tok       = in_data;
               m_last      = in_data;
               m_owe_a     = 1'b1;
               m_owe_b     = 1'b1;
               m_accepting = 1'b0;
            end
         end else if (!m_idle) begin
            if (out_a_ready) m_owe_a = 1'b0;
            if (out_b_ready) m_owe_b = 1'b0;
            if (!m_owe_a && !m_owe_b) m_count = (m_count + 1) % (1 << CNT_W);
         end else if (m_leave) begin
            m_accepting = 1'b1;
         end
         if (m_leave)     m_pend = 1'b0;
         else if (m_edge) m_pend = 1'b1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk_in) begin
      if (chk_en) begin
         chk("in_ready",    32'(in_ready),    32'(m_accepting));
         chk("out_a_valid", 32'(out_a_valid), 32'(m_owe_a));
         chk("out_b_valid", 32'(out_b_valid), 32'(m_owe_b));
         chk("out_a_data",  32'(out_a_data),  32'(m_tok));
         chk("out_b_data",  32'(out_b_data),  32'(m_tok));
         chk("last_token",  32'(last_token),  32'(m_last));
         chk("token_count", 32'(token_count), m_count);
         chk("tick_lost",   32'(tick_lost),   32'(m_lost));
      end
   end

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic tick_pulse();
      tick_src = 1'b0;
      cyc();
      tick_src = 1'b1;
      cyc();
   endtask

   // Offer one token, optionally preceded by a tick edge, and confirm its capture.
   task automatic send(input logic [W-1:0] d, input bit pulse);
      int unsigned n = 0;
      in_data  = d;
      in_valid = 1'b1;
      if (pulse) begin
         tick_src = 1'b0;
         cyc();
         tick_src = 1'b1;
      end
      while (in_ready !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      chk("send_in_ready", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("send_a_valid", 32'(out_a_valid), 32'd1);
      chk("send_b_valid", 32'(out_b_valid), 32'd1);
      chk("send_a_data",  32'(out_a_data),  32'(d));
      chk("send_last",    32'(last_token),  32'(d));
   endtask

   initial begin
      // Reset with tick held high.
      reset    = 1'b1;
      tick_src = 1'b1;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("rst_in_ready", 32'(in_ready),    32'd0);
      chk("rst_a_valid",  32'(out_a_valid), 32'd0);
      chk("rst_a_data",   32'(out_a_data),  32'd0);
      chk("rst_last",     32'(last_token),  32'd0);
      chk("rst_count",    32'(token_count), 32'd0);
      reset = 1'b0;
      repeat (10) cyc();
      chk("idle_in_ready", 32'(in_ready), PACED ? 32'd0 : 32'd1);
      chk("idle_tick_lost", 32'(tick_lost), 32'd0);

      // Single token, both consumers ready.
      send(8'hA5, PACED);
      cyc();
      chk("single_count", 32'(token_count), 32'd1);
      chk("single_a_valid", 32'(out_a_valid), 32'd0);

      // Skewed consumers: B stalls while A takes the token at once.
      out_b_ready = 1'b0;
      send(8'h3C, PACED);
      cyc();
      chk("skew_a_drop", 32'(out_a_valid), 32'd0);
      repeat (19) cyc();
      chk("skew_b_hold", 32'(out_b_valid), 32'd1);
      chk("skew_b_data", 32'(out_b_data),  32'h3C);
      chk("skew_count_held", 32'(token_count), 32'd1);
      out_b_ready = 1'b1;
      cyc();
      chk("skew_count", 32'(token_count), 32'd2);
      chk("skew_b_drop", 32'(out_b_valid), 32'd0);

      // Tick overrun during a stalled delivery.
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      send(8'h5A, PACED);
      repeat (3) tick_pulse();
      chk("overrun_lost", 32'(tick_lost), 32'(PACED));
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      cyc();
      chk("overrun_count", 32'(token_count), 32'd3);
      cyc();
      chk("overrun_extra_accept", 32'(in_ready), 32'd1);
      send(8'h77, 1'b0);
      cyc();
      repeat (5) cyc();
      chk("overrun_no_second", 32'(in_ready), PACED ? 32'd0 : 32'd1);
      chk("overrun_count2", 32'(token_count), 32'd4);
      chk("overrun_sticky", 32'(tick_lost), 32'(PACED));

      // Counter wrap with a 4-bit counter.
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      chk("wrap_rst_lost", 32'(tick_lost), 32'd0);
      for (int i = 1; i <= 17; i++) begin
         send(W'(i * 7 + 3), PACED);
         cyc();
         chk("wrap_count", 32'(token_count), 32'(i % 16));
      end

      // Reset while both valids are high discards the token.
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      send(8'hC3, PACED);
      reset = 1'b1;
      cyc();
      chk("midrst_a_valid", 32'(out_a_valid), 32'd0);
      chk("midrst_b_valid", 32'(out_b_valid), 32'd0);
      chk("midrst_count",   32'(token_count), 32'd0);
      chk("midrst_last",    32'(last_token),  32'd0);
      reset = 1'b0;
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      cyc();
      chk("midrst_count_after", 32'(token_count), 32'd0);

`ifndef SPLIT_PACE_EN
      // Full-rate flow: four tokens at a three-cycle period.
      reset = 1'b1;
      cyc();
      reset    = 1'b0;
      in_data  = 8'h42;
      in_valid = 1'b1;
      repeat (11) cyc();
      chk("rate_count3", 32'(token_count), 32'd3);
      chk("rate_deliver", 32'(out_a_valid), 32'd1);
      cyc();
      chk("rate_count4", 32'(token_count), 32'd4);
      in_valid = 1'b0;
      repeat (3) cyc();
`endif

      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
